// File: rtl/feeder_pkg.sv
// feeder_pkg: FSM state type and default parameters shared by fifo_burst_reader and its buffer.
package feeder_pkg;
  localparam int RSA_DW_DEF    = 8;
  localparam int BURST_MAX_DEF = 8;
  localparam int LEN_W_DEF     = 4;
  localparam int TIMEOUT_DEF   = 16;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/feeder_skid_buf.sv
// feeder_skid_buf: 2-entry in-order buffer between the FIFO read port and the output stream.
module feeder_skid_buf
  import feeder_pkg::*;
#(
  parameter int DW = RSA_DW_DEF
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);
  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr, r_rd_ptr;
  logic [1:0]    r_occ;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign occ  = r_occ;
  assign head = r_mem[r_rd_ptr];
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a bounded burst from a sync FIFO and streams it out with last/done.
// Define FEEDER_TIMEOUT_EN to abort a burst after TIMEOUT consecutive empty-FIFO stall cycles.
module fifo_burst_reader
  import feeder_pkg::*;
#(
  parameter int RSA_DW    = RSA_DW_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [RSA_DW-1:0] fifo_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RSA_DW-1:0] out_data,
  output logic              out_last
);
  localparam logic [LEN_W:0] L_MAX = (LEN_W+1)'(BURST_MAX);

  if (TIMEOUT < 1 || (2 ** LEN_W) <= BURST_MAX) begin : g_cfg_check
    $error("fifo_burst_reader: requires TIMEOUT >= 1 and 2**LEN_W > BURST_MAX");
  end

  state_t         r_state, w_state_nxt;
  logic [LEN_W:0] r_len, r_req_cnt, r_out_cnt, w_len_in;
  logic           r_inflight, r_zero_done;
  logic           w_pop, w_fin, w_to, w_abort;
  logic [1:0]     w_occ;

  assign w_len_in  = ({1'b0, burst_len} > L_MAX) ? L_MAX : {1'b0, burst_len};
  assign out_valid = w_occ != 2'd0;
  assign w_pop     = out_valid && out_ready;
  assign w_fin     = w_abort ? (w_occ == 2'd0 && !r_inflight) : (w_pop && out_last);

  feeder_skid_buf #(.DW(RSA_DW)) u_buf (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .push     (r_inflight),
    .pop      (w_pop),
    .din      (fifo_data),
    .occ      (w_occ),
    .head     (out_data)
  );

`ifdef FEEDER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] r_stall;
  logic               r_abort;
  assign w_to    = r_state == S_RUN && r_stall == STALL_W'(TIMEOUT);
  assign w_abort = r_abort;
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      r_stall <= (r_state == S_RUN && r_req_cnt < r_len && fifo_empty && !w_to) ? r_stall + 1'b1 : '0;
      r_abort <= (r_state == S_IDLE) ? 1'b0 : (r_abort | w_to);
    end
  end
`else
  assign w_to    = 1'b0;
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && w_len_in != '0) w_state_nxt = S_RUN;
      S_RUN:   if (r_req_cnt == r_len || w_to) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_fin) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The occupancy term keeps buffered plus in-flight words within the 2-entry buffer.
  always_comb begin
    busy       = r_state != S_IDLE;
    fifo_rd_en = r_state == S_RUN && !w_to && !fifo_empty && r_req_cnt < r_len &&
                 ({1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2;
    out_last   = out_valid && !w_abort && r_out_cnt == r_len - 1'b1;
    done       = r_zero_done || (r_state == S_DRAIN && w_fin);
    err        = r_state == S_DRAIN && w_fin && w_abort;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_len       <= '0;
      r_req_cnt   <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_inflight  <= fifo_rd_en;
      r_zero_done <= r_state == S_IDLE && start && w_len_in == '0;
      if (r_state == S_IDLE && start) begin
        r_len     <= w_len_in;
        r_req_cnt <= '0;
        r_out_cnt <= '0;
      end else begin
        if (fifo_rd_en) r_req_cnt <= r_req_cnt + 1'b1;
        if (w_pop)      r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter RSA_DW, default 8: data word width, equal to the upstream sync FIFO width.
REQ-002 SHALL have parameter BURST_MAX, default 8: maximum words per burst.
REQ-003 SHALL have parameter LEN_W, default 4: width of burst_len; 2^LEN_W > BURST_MAX.
REQ-004 SHALL have parameter TIMEOUT, default 16: stall limit in cycles; used only under FEEDER_TIMEOUT_EN.
REQ-005 clk  in  1  single clock; all logic rises on posedge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle burst request; sampled only in IDLE.
REQ-008 burst_len  in  LEN_W  words to transfer; sampled with start.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle abort pulse, coincident with done; tied 0 without FEEDER_TIMEOUT_EN.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 fifo_rd_en  out  1  FIFO read strobe.
REQ-014 fifo_data  in  RSA_DW  FIFO read data, valid the cycle after an accepted read.
REQ-015 out_valid / out_ready / out_data(RSA_DW) / out_last  out/in/out/out  downstream stream; a beat transfers when valid && ready.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; encoding in the package.
REQ-017 IDLE: start=1 SHALL latch len = min(burst_len, BURST_MAX), clear counters, enter RUN next cycle; len=0 SHALL pulse done next cycle, stay IDLE, issue no reads.
REQ-018 fifo_rd_en SHALL be combinational, high only when state=RUN, !fifo_empty, req_cnt<len, and buf_occ + inflight - pop < 2, where pop = out_valid && out_ready.
REQ-019 Every fifo_rd_en assertion SHALL be a completed read; req_cnt SHALL increment per assertion; inflight SHALL be rd_en registered.
REQ-020 fifo_data SHALL be written into a 2-entry buffer on the cycle inflight=1; out_valid SHALL rise the following cycle (start at t0 -> rd_en t1 -> fifo_data t2 -> out_valid t3 minimum).
REQ-021 Sustained ready=1 with a non-empty FIFO SHALL yield one beat per cycle.
REQ-022 out_data SHALL hold the buffer head while out_valid=0 and stay stable while out_valid && !out_ready.
REQ-023 out_last SHALL be high exactly on the beat where out_cnt = len-1.
REQ-024 RUN SHALL go to DRAIN when req_cnt=len; DRAIN SHALL go to IDLE on the accepted out_last beat, with done pulsed that same cycle.
REQ-025 start while busy SHALL be ignored; burst_len changes after latch SHALL have no effect.
REQ-026 Counters SHALL be LEN_W+1 bits wide; no wrap within a burst.
REQ-027 Simultaneous buffer write and pop SHALL keep buf_occ unchanged and preserve order.

Reset
REQ-028 sys_rst_n low SHALL asynchronously force IDLE, and set busy, done, err, fifo_rd_en, out_valid, out_last, and out_data to 0.
REQ-029 Reset mid-burst SHALL discard buffered and in-flight words; the FIFO is not re-synchronised by this block.

Configuration
REQ-030 With FEEDER_TIMEOUT_EN defined, a stall counter SHALL count consecutive RUN cycles with req_cnt<len and fifo_empty=1, clearing on any read.
REQ-031 With FEEDER_TIMEOUT_EN defined, reaching TIMEOUT SHALL stop reads, drain buffered words (out_last unasserted), then pulse done and err together and return to IDLE.
REQ-032 Without FEEDER_TIMEOUT_EN, no stall counter SHALL exist, err SHALL be constant 0, and the block SHALL wait indefinitely.

Structure
REQ-033 Package feeder_pkg SHALL hold the FSM state typedef and the default RSA_DW, BURST_MAX, LEN_W and TIMEOUT constants.
REQ-034 The 2-entry buffer SHALL be sub-module feeder_skid_buf (push, pop, occ, head).

Verification
REQ-035 FIFO preloaded with 0x11..0x14, start with len=4, ready=1 -> rd_en at t1..t4, beats 0x11..0x14 at t3..t6, out_last and done at t6.
REQ-036 len=4 with ready toggling 1/0 -> same four beats in order, none dropped or duplicated, out_data stable while stalled, rd_en never raises occupancy above 2.
REQ-037 len=0 -> done at t1, busy stays 0, fifo_rd_en never asserts; len=12 -> exactly 8 beats.
REQ-038 len=3 with the FIFO emptying after 1 word and refilled 5 cycles later -> 3 beats, done with err=0; with FEEDER_TIMEOUT_EN defined and TIMEOUT=4 and no refill -> 1 beat, then done with err=1.
REQ-039 Reset asserted at the 2nd beat of len=6 -> all outputs 0 immediately; a new start with len=2 after release -> correct 2-beat burst.
